// File: rtl/pe_pkg.sv
// Shared types and helpers for the border-PE sequencer: FSM state encoding,
// unary stream length and the two's-complement to sign-magnitude conversion.
package pe_pkg;

  localparam int PE_IWIDTH = 8;
  localparam int UNARY_LEN = 1 << (PE_IWIDTH - 1);

  typedef enum logic [2:0] {IDLE, CLR, LOADW, FETCH, RUN, DONE} seq_state_t;

  // The most negative code has no positive twin, so it saturates to all ones
  function automatic logic [PE_IWIDTH-2:0] sm_abs(input logic signed [PE_IWIDTH-1:0] x);
    logic [PE_IWIDTH-2:0] low;
    low = x[PE_IWIDTH-2:0];
    if (!x[PE_IWIDTH-1])
      return low;
    else if (low == '0)
      return '1;
    else
      return ~low + 1'b1;
  endfunction

endpackage

// File: rtl/sm_conv.sv
// Registered sign/magnitude split of a weight word, loaded on handshake and
// held until the next load.
module sm_conv
  import pe_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        load,
  input  logic signed [PE_IWIDTH-1:0] word,
  output logic                        sign,
  output logic [PE_IWIDTH-2:0]        mag
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign <= 1'b0;
      mag  <= '0;
    end else if (load) begin
      sign <= word[PE_IWIDTH-1];
      mag  <= sm_abs(word);
    end
  end

endmodule

// File: rtl/pe_border_seq.sv
// Job sequencer and operand feeder for the border PE of a unary-rate systolic
// column: handshakes weight/ifm words and drives registered PE strobes.
module pe_border_seq
  import pe_pkg::*;
#(
  parameter int IWIDTH = PE_IWIDTH,
  parameter int KWIDTH = 8,
  parameter int CWIDTH = IWIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [KWIDTH-1:0]        num_mac,
  input  logic [CWIDTH-1:0]        cycles_per_mac,
  output logic                     busy,
  output logic                     done,
  input  logic                     wght_valid,
  output logic                     wght_ready,
  input  logic signed [IWIDTH-1:0] wght_in,
  input  logic                     ifm_valid,
  output logic                     ifm_ready,
  input  logic signed [IWIDTH-1:0] ifm_in,
  output logic signed [IWIDTH-1:0] ifm,
  output logic                     wght_sign,
  output logic [IWIDTH-2:0]        wght_abs,
  output logic                     en_i,
  output logic                     clr_i,
  output logic                     en_w,
  output logic                     clr_w,
  output logic                     en_o,
  output logic                     clr_o,
  output logic                     mac_done
);

  seq_state_t        state, state_n;
  logic [KWIDTH-1:0] num_mac_q;
  logic [KWIDTH-1:0] mac_cnt;
  logic [CWIDTH-1:0] cpm_q;
  logic [CWIDTH-1:0] cyc_cnt;
  logic              wght_hs, ifm_hs, run_last;

  assign wght_hs  = (state == LOADW) && wght_valid;
  assign ifm_hs   = (state == FETCH) && ifm_valid;
  assign run_last = (state == RUN) && (cyc_cnt == CWIDTH'(1));

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = CLR;
      CLR:     state_n = LOADW;
      LOADW:   if (wght_hs) state_n = (num_mac_q == '0) ? DONE : FETCH;
      FETCH:   if (ifm_hs) state_n = RUN;
      RUN:     if (run_last) state_n = (mac_cnt == num_mac_q - KWIDTH'(1)) ? DONE : FETCH;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Every strobe is registered from this cycle's decision, so it lands on
  // the cycle that follows; en_o therefore trails the RUN state by one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      num_mac_q  <= '0;
      cpm_q      <= '0;
      mac_cnt    <= '0;
      cyc_cnt    <= '0;
      ifm        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      wght_ready <= 1'b0;
      ifm_ready  <= 1'b0;
      en_i       <= 1'b0;
      clr_i      <= 1'b0;
      en_w       <= 1'b0;
      clr_w      <= 1'b0;
      en_o       <= 1'b0;
      clr_o      <= 1'b0;
      mac_done   <= 1'b0;
    end else begin
      state <= state_n;
      if ((state == IDLE) && start) begin
        num_mac_q <= num_mac;
        cpm_q     <= (cycles_per_mac == '0) ? CWIDTH'(UNARY_LEN) : cycles_per_mac;
        mac_cnt   <= '0;
      end
      if (ifm_hs) begin
        cyc_cnt <= cpm_q;
        ifm     <= ifm_in;
      end else if (state == RUN) begin
        cyc_cnt <= cyc_cnt - CWIDTH'(1);
      end
      if (run_last) mac_cnt <= mac_cnt + KWIDTH'(1);
      busy       <= (state_n != IDLE);
      done       <= (state_n == DONE);
      wght_ready <= (state_n == LOADW);
      ifm_ready  <= (state_n == FETCH);
      clr_i      <= (state_n == CLR);
      clr_w      <= (state_n == CLR);
      clr_o      <= (state_n == CLR);
      en_w       <= wght_hs;
      en_i       <= ifm_hs;
      en_o       <= (state == RUN);
      mac_done   <= run_last;
    end
  end

  sm_conv u_sm_conv (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (wght_hs),
    .word  (wght_in),
    .sign  (wght_sign),
    .mag   (wght_abs)
  );

endmodule

// File: tb/tb_pe_border_seq.sv
// Scoreboard bench for pe_border_seq: each job pushes its expected strobe
// events; a negedge monitor pops and compares them as the DUT emits them.
module tb_pe_border_seq;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [7:0]        num_mac;
  logic [7:0]        cycles_per_mac;
  logic              busy, done;
  logic              wght_valid, wght_ready;
  logic signed [7:0] wght_in;
  logic              ifm_valid, ifm_ready;
  logic signed [7:0] ifm_in;
  logic signed [7:0] ifm;
  logic              wght_sign;
  logic [6:0]        wght_abs;
  logic              en_i, clr_i, en_w, clr_w, en_o, clr_o, mac_done;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  int          run_len = 0;
  int          ifm_tab[12] = '{5, -7, 100, -1, 64, 1, 2, 3, 11, 12, -128, 127};

  localparam logic [7:0] K_CLR = 8'd1, K_W = 8'd2, K_I = 8'd3, K_MD = 8'd4, K_DONE = 8'd5;

  always #5 clk = ~clk;

  pe_border_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_mac(num_mac),
    .cycles_per_mac(cycles_per_mac), .busy(busy), .done(done),
    .wght_valid(wght_valid), .wght_ready(wght_ready), .wght_in(wght_in),
    .ifm_valid(ifm_valid), .ifm_ready(ifm_ready), .ifm_in(ifm_in),
    .ifm(ifm), .wght_sign(wght_sign), .wght_abs(wght_abs),
    .en_i(en_i), .clr_i(clr_i), .en_w(en_w), .clr_w(clr_w),
    .en_o(en_o), .clr_o(clr_o), .mac_done(mac_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_cmp(input string tag, input logic [31:0] obs);
    if (exp_q.size() == 0) check({tag, "_unexpected"}, obs, 32'hFFFF_FFFF);
    else check(tag, obs, exp_q.pop_front());
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({busy, done, wght_ready, ifm_ready, ifm, wght_sign, wght_abs,
                en_i, clr_i, en_w, clr_w, en_o, clr_o, mac_done});
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (en_i && en_o) check("en_i_en_o_overlap", 1, 0);
      if (clr_i) begin
        check("clr_all", 32'({clr_w, clr_o}), 32'd3);
        pop_cmp("clr", {K_CLR, 24'd0});
      end
      if (en_w) pop_cmp("wght", {K_W, 16'd0, wght_sign, wght_abs});
      if (en_i) begin
        pop_cmp("ifm", {K_I, 16'd0, ifm});
        run_len = 0;
      end
      if (en_o) run_len++;
      if (mac_done) pop_cmp("mac_done_len", {K_MD, 24'(en_o ? run_len : 0)});
      if (done) pop_cmp("done", {K_DONE, 24'd0});
    end
  end

  task automatic run_job(input int nm, input int cpm, input int w, input int stall,
                         input bit poke, input bit abort, input int base);
    int  t;
    int  mag;
    bit  sgn;
    sgn = (w < 0);
    mag = (w == -128) ? 127 : ((w < 0) ? -w : w);
    exp_q.push_back({K_CLR, 24'd0});
    exp_q.push_back({K_W, 16'd0, sgn, 7'(mag)});
    for (int k = 0; k < nm; k++) begin
      exp_q.push_back({K_I, 16'd0, 8'(ifm_tab[base + k])});
      exp_q.push_back({K_MD, 24'((cpm == 0) ? 128 : cpm)});
    end
    exp_q.push_back({K_DONE, 24'd0});

    @(negedge clk);
    start = 1'b1; num_mac = 8'(nm); cycles_per_mac = 8'(cpm);
    @(negedge clk);
    start = 1'b0;
    check("clr_after_start", 32'(clr_i), 1);
    check("busy_after_start", 32'(busy), 1);
    @(negedge clk);
    check("clr_one_cycle", 32'(clr_i), 0);
    check("wght_ready_loadw", 32'(wght_ready), 1);

    wght_valid = 1'b1; wght_in = 8'(w);
    t = 0;
    while (!wght_ready && t < 20) begin @(negedge clk); t++; end
    if (!wght_ready) begin check("wght_ready_timeout", 0, 1); return; end
    @(posedge clk);
    @(negedge clk);
    wght_valid = 1'b0; wght_in = 8'h55;
    check("wght_ready_drop", 32'(wght_ready), 0);

    for (int k = 0; k < nm; k++) begin
      if (k == 0) begin
        for (int s = 0; s < stall; s++) begin
          check("stall_ready", 32'(ifm_ready), 1);
          check("stall_strobes", 32'({en_i, en_o, mac_done}), 0);
          @(negedge clk);
        end
      end
      ifm_valid = 1'b1; ifm_in = 8'(ifm_tab[base + k]);
      t = 0;
      while (!ifm_ready && t < 300) begin @(negedge clk); t++; end
      if (!ifm_ready) begin check("ifm_ready_timeout", 0, 1); ifm_valid = 1'b0; return; end
      @(posedge clk);
      @(negedge clk);
      if (k == 0 && stall > 0) check("en_i_after_valid", 32'(en_i), 1);
      if (k == 0 && abort) begin
        @(negedge clk);
        rst_n = 1'b0;
        ifm_valid = 1'b0;
        #1;
        check("abort_outputs_zero", all_outs(), 0);
        exp_q.delete();
        return;
      end
      if (k == 0 && poke) begin
        start = 1'b1; num_mac = 8'd5;
        @(negedge clk);
        start = 1'b0; num_mac = 8'(nm);
      end
    end
    ifm_valid = 1'b0;

    t = 0;
    while (!done && t < 400) begin @(negedge clk); t++; end
    check("done_seen", 32'(done), 1);
    check("busy_at_done", 32'(busy), 1);
    @(negedge clk);
    check("busy_after_done", 32'(busy), 0);
    check("done_one_cycle", 32'(done), 0);
    check("scoreboard_drained", 32'(exp_q.size()), 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; num_mac = '0; cycles_per_mac = '0;
    wght_valid = 1'b0; wght_in = '0; ifm_valid = 1'b0; ifm_in = '0;
    #3;
    check("reset_outputs", all_outs(), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_job(2, 4, -3, 0, 1'b0, 1'b0, 0);
    run_job(1, 0, -128, 0, 1'b0, 1'b0, 2);
    run_job(2, 3, 6, 10, 1'b0, 1'b0, 3);
    run_job(0, 5, 77, 0, 1'b0, 1'b0, 0);
    run_job(3, 4, -1, 0, 1'b1, 1'b0, 5);

    run_job(2, 4, 9, 0, 1'b0, 1'b1, 8);
    repeat (2) @(negedge clk);
    check("held_reset_zero", all_outs(), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_after_abort", 32'({busy, done}), 0);
    run_job(2, 2, -100, 0, 1'b0, 1'b0, 10);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
